// File: rtl/aud_sram_ctrl.sv
// Recorder-to-SRAM write buffer with an arbitrated playback read port on one async 1Mx16 SRAM.
// Writes hold WE_N low WR_CYCLES, reads OE_N low RD_CYCLES (valid the cycle after); a full FIFO drops samples and sets a sticky flag.
module aud_sram_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int WR_CYCLES  = 2,
  parameter int RD_CYCLES  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rec_valid,
  input  logic [19:0] i_rec_addr,
  input  logic [15:0] i_rec_data,
  input  logic        i_rec_clear,
  output logic        o_overflow,
  input  logic        i_rd_req,
  input  logic [19:0] i_rd_addr,
  output logic        o_rd_valid,
  output logic [15:0] o_rd_data,
  output logic [19:0] o_end_addr,
  output logic        o_has_data,
  output logic [19:0] o_sram_addr,
  inout  wire  [15:0] io_sram_dq,
  output logic        o_sram_we_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_ce_n,
  output logic        o_sram_lb_n,
  output logic        o_sram_ub_n
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CMAX = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_wr_q, last_wr_d;
  logic          wr_abandon_q, wr_abandon_d;
  logic [19:0]   sram_addr_q, sram_addr_d;
  logic [15:0]   dq_out_q, dq_out_d;
  logic          we_n_q, we_n_d;
  logic          oe_n_q, oe_n_d;
  logic          rd_valid_q, rd_valid_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic [19:0]   end_addr_q, end_addr_d;
  logic          has_data_q, has_data_d;
  logic          overflow_q, overflow_d;

  logic [19:0]   fifo_addr_mem [FIFO_DEPTH];
  logic [15:0]   fifo_data_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_idx;
  logic          fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic          wr_done, rd_done, commit, rd_pend, go_wr, go_rd;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign wr_done = (state_q == ST_WRITE) && (cnt_q == WR_LAST);
  assign rd_done = (state_q == ST_READ) && (cnt_q == RD_LAST);

  // A write whose queue entry was flushed by a clear still finishes on the pins but is not reported.
  assign commit    = wr_done && !wr_abandon_q && !i_rec_clear;
  assign fifo_pop  = commit;
  assign fifo_push = i_rec_valid && (i_rec_clear || !fifo_full || fifo_pop);
  assign wr_idx    = i_rec_clear ? '0 : wr_ptr_q[AW-1:0];

  assign rd_pend = i_rd_req && !rd_valid_q;
  assign go_wr   = !fifo_empty && !i_rec_clear && (!rd_pend || !last_wr_q);
  assign go_rd   = rd_pend && (fifo_empty || last_wr_q);

  always_ff @(posedge i_clk) begin
    if (fifo_push) begin
      fifo_addr_mem[wr_idx] <= i_rec_addr;
      fifo_data_mem[wr_idx] <= i_rec_data;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    end_addr_d = end_addr_q;
    has_data_d = has_data_q;
    if (i_rec_clear) begin
      wr_ptr_d   = fifo_push ? (AW+1)'(1) : '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
      end_addr_d = '0;
      has_data_d = 1'b0;
    end else begin
      if (fifo_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (fifo_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      if (i_rec_valid && !fifo_push) overflow_d = 1'b1;
      if (commit) begin
        end_addr_d = sram_addr_q;
        has_data_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_wr_d    = last_wr_q;
    wr_abandon_d = wr_abandon_q;
    sram_addr_d  = sram_addr_q;
    dq_out_d     = dq_out_q;
    we_n_d       = we_n_q;
    oe_n_d       = oe_n_q;
    rd_valid_d   = 1'b0;
    rd_data_d    = rd_data_q;
    case (state_q)
      ST_IDLE: begin
        if (go_wr) begin
          state_d      = ST_WRITE;
          cnt_d        = '0;
          last_wr_d    = 1'b1;
          wr_abandon_d = 1'b0;
          sram_addr_d  = fifo_addr_mem[rd_ptr_q[AW-1:0]];
          dq_out_d     = fifo_data_mem[rd_ptr_q[AW-1:0]];
          we_n_d       = 1'b0;
        end else if (go_rd) begin
          state_d     = ST_READ;
          cnt_d       = '0;
          last_wr_d   = 1'b0;
          sram_addr_d = i_rd_addr;
          oe_n_d      = 1'b0;
        end
      end
      ST_WRITE: begin
        if (i_rec_clear) wr_abandon_d = 1'b1;
        if (wr_done) begin
          state_d = ST_IDLE;
          we_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_READ: begin
        if (rd_done) begin
          state_d    = ST_IDLE;
          oe_n_d     = 1'b1;
          rd_data_d  = io_sram_dq;
          rd_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_wr_q    <= 1'b0;
      wr_abandon_q <= 1'b0;
      sram_addr_q  <= '0;
      dq_out_q     <= '0;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      end_addr_q   <= '0;
      has_data_q   <= 1'b0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_wr_q    <= last_wr_d;
      wr_abandon_q <= wr_abandon_d;
      sram_addr_q  <= sram_addr_d;
      dq_out_q     <= dq_out_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      end_addr_q   <= end_addr_d;
      has_data_q   <= has_data_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // The data bus is only driven while WE_N is low, so it can never fight the SRAM during a read.
  assign io_sram_dq  = we_n_q ? {16{1'bz}} : dq_out_q;
  assign o_sram_addr = sram_addr_q;
  assign o_sram_we_n = we_n_q;
  assign o_sram_oe_n = oe_n_q;
  assign o_sram_ce_n = 1'b0;
  assign o_sram_lb_n = 1'b0;
  assign o_sram_ub_n = 1'b0;
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_data   = rd_data_q;
  assign o_end_addr  = end_addr_q;
  assign o_has_data  = has_data_q;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_aud_sram_ctrl.sv
// Directed bench for aud_sram_ctrl: queue-based transaction model checked every cycle, plus literal checks.
module tb_aud_sram_ctrl;

  localparam int DEPTH = 4;
  localparam int WRC   = 2;
  localparam int RDC   = 2;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_rec_valid = 1'b0;
  logic [19:0] i_rec_addr = '0;
  logic [15:0] i_rec_data = '0;
  logic        i_rec_clear = 1'b0;
  logic        i_rd_req = 1'b0;
  logic [19:0] i_rd_addr = '0;
  logic        o_overflow, o_rd_valid, o_has_data;
  logic [15:0] o_rd_data;
  logic [19:0] o_end_addr, o_sram_addr;
  logic        o_sram_we_n, o_sram_oe_n, o_sram_ce_n, o_sram_lb_n, o_sram_ub_n;
  wire  [15:0] io_sram_dq;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 i_clk = ~i_clk;

  aud_sram_ctrl #(.FIFO_DEPTH(DEPTH), .WR_CYCLES(WRC), .RD_CYCLES(RDC)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_rec_valid(i_rec_valid), .i_rec_addr(i_rec_addr), .i_rec_data(i_rec_data),
    .i_rec_clear(i_rec_clear), .o_overflow(o_overflow),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .o_end_addr(o_end_addr), .o_has_data(o_has_data),
    .o_sram_addr(o_sram_addr), .io_sram_dq(io_sram_dq),
    .o_sram_we_n(o_sram_we_n), .o_sram_oe_n(o_sram_oe_n),
    .o_sram_ce_n(o_sram_ce_n), .o_sram_lb_n(o_sram_lb_n), .o_sram_ub_n(o_sram_ub_n)
  );

  // External SRAM: 256 words are enough for the addresses used here.
  logic [15:0] sram_mem [256];
  logic [15:0] sram_rd;
  assign sram_rd    = sram_mem[o_sram_addr[7:0]];
  assign io_sram_dq = (!o_sram_oe_n && o_sram_we_n) ? sram_rd : 16'hzzzz;

  function automatic logic [15:0] preload(input int a);
    return 16'(a) ^ 16'h5A00;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) sram_mem[i] = preload(i);
    sram_mem[16] = 16'h83C1;
    forever begin
      @(posedge i_clk);
      if (!o_sram_we_n) sram_mem[o_sram_addr[7:0]] = io_sram_dq;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a sample queue plus the single SRAM operation in flight.
  typedef struct packed {
    logic [19:0] a;
    logic [15:0] d;
  } ent_t;

  ent_t        m_q[$];
  int          m_op;      // 0 none, 1 write, 2 read
  int          m_left;    // edges remaining until the current operation ends
  logic [19:0] m_addr;
  logic [15:0] m_data;
  bit          m_abandon, m_last_wr, m_ovf, m_has, m_rdv;
  logic [19:0] m_end;
  logic [15:0] m_rdd;
  int          m_n;
  bit          m_done, m_rdp, m_pop;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_q.delete();
      m_op = 0; m_left = 0; m_addr = '0; m_data = '0;
      m_abandon = 0; m_last_wr = 0; m_ovf = 0; m_has = 0; m_rdv = 0;
      m_end = '0; m_rdd = '0;
    end else begin
      m_n    = m_q.size();
      m_rdp  = i_rd_req && !m_rdv;
      m_done = (m_op != 0) && (m_left == 1);
      m_pop  = 0;
      m_rdv  = 0;
      if (m_done) begin
        if (m_op == 1) begin
          if (!m_abandon && !i_rec_clear) begin
            void'(m_q.pop_front());
            m_pop = 1;
            m_end = m_addr;
            m_has = 1;
          end
        end else begin
          m_rdd = sram_mem[m_addr[7:0]];
          m_rdv = 1;
        end
        m_op = 0;
      end else if (m_op != 0) begin
        m_left--;
        if (m_op == 1 && i_rec_clear) m_abandon = 1;
      end else if (m_n > 0 && !i_rec_clear && (!m_rdp || !m_last_wr)) begin
        m_op = 1; m_left = WRC; m_addr = m_q[0].a; m_data = m_q[0].d;
        m_abandon = 0; m_last_wr = 1;
      end else if (m_rdp && (m_n == 0 || m_last_wr)) begin
        m_op = 2; m_left = RDC; m_addr = i_rd_addr; m_last_wr = 0;
      end
      if (i_rec_clear) begin
        m_q.delete();
        m_ovf = 0; m_end = '0; m_has = 0;
        if (i_rec_valid) m_q.push_back(ent_t'({i_rec_addr, i_rec_data}));
      end else if (i_rec_valid) begin
        if (m_n == DEPTH && !m_pop) m_ovf = 1;
        else m_q.push_back(ent_t'({i_rec_addr, i_rec_data}));
      end
    end
  end

  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("we_n", o_sram_we_n, m_op != 1);
      chk("oe_n", o_sram_oe_n, m_op != 2);
      chk("sram_addr", o_sram_addr, m_addr);
      chk("rd_valid", o_rd_valid, m_rdv);
      chk("rd_data", o_rd_data, m_rdd);
      chk("end_addr", o_end_addr, m_end);
      chk("has_data", o_has_data, m_has);
      chk("overflow", o_overflow, m_ovf);
      chk("ce_lb_ub", {o_sram_ce_n, o_sram_lb_n, o_sram_ub_n}, 3'b000);
      chk("no_overlap", o_sram_we_n | o_sram_oe_n, 1'b1);
      if (m_op == 1) chk("dq", io_sram_dq, m_data);
    end
  end

  // Grant order: 1 = write start, 2 = read start.
  int grant_log[$];
  logic prev_we = 1'b1, prev_oe = 1'b1;
  always @(negedge i_clk) begin
    if (!o_sram_we_n && prev_we) grant_log.push_back(1);
    if (!o_sram_oe_n && prev_oe) grant_log.push_back(2);
    prev_we = o_sram_we_n;
    prev_oe = o_sram_oe_n;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [19:0] a, input logic [15:0] d);
    i_rec_valid = 1'b1; i_rec_addr = a; i_rec_data = d;
    tick();
    i_rec_valid = 1'b0;
  endtask

  int exp_ord[4] = '{1, 2, 1, 1};
  bit seen;
  int pulses;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("rst_we_n", o_sram_we_n, 1'b1);
    chk("rst_oe_n", o_sram_oe_n, 1'b1);
    chk("rst_addr", o_sram_addr, 20'h0);
    chk("rst_flags", {o_rd_valid, o_has_data, o_overflow}, 3'b000);
    chk("rst_data", {o_rd_data, o_end_addr}, 36'h0);
    i_rst_n = 1'b1;
    chk_en  = 1'b1;
    tick();

    // Single write: push at edge N, WE_N low N+1..N+2, commit at N+3.
    push(20'h00003, 16'hF2CF);
    chk("w1_pre_we", o_sram_we_n, 1'b1);
    tick();
    chk("w1_we_lo1", o_sram_we_n, 1'b0);
    chk("w1_dq", io_sram_dq, 16'hF2CF);
    chk("w1_addr", o_sram_addr, 20'h00003);
    tick();
    chk("w1_we_lo2", o_sram_we_n, 1'b0);
    chk("w1_has_pre", o_has_data, 1'b0);
    tick();
    chk("w1_we_hi", o_sram_we_n, 1'b1);
    chk("w1_end", o_end_addr, 20'h00003);
    chk("w1_has", o_has_data, 1'b1);

    // Six back-to-back samples: only the sixth finds the FIFO full.
    for (int i = 0; i < 6; i++) push(20'h40 + 20'(i), 16'h1000 + 16'(i));
    chk("ovf_set", o_overflow, 1'b1);
    repeat (12) tick();
    chk("ovf_end", o_end_addr, 20'h00044);
    chk("ovf_sticky", o_overflow, 1'b1);
    chk("ovf_dropped", sram_mem[8'h45], preload(8'h45));
    chk("ovf_kept", sram_mem[8'h44], 16'h1004);
    i_rec_clear = 1'b1;
    tick();
    i_rec_clear = 1'b0;
    chk("clr_ovf", o_overflow, 1'b0);
    chk("clr_end", o_end_addr, 20'h0);
    chk("clr_has", o_has_data, 1'b0);

    // Read with an empty FIFO: request visible in cycle M, valid in cycle M+3.
    i_rd_addr = 20'h00010;
    i_rd_req  = 1'b1;
    tick();
    chk("rd_oe_lo1", o_sram_oe_n, 1'b0);
    chk("rd_addr", o_sram_addr, 20'h00010);
    tick();
    chk("rd_oe_lo2", o_sram_oe_n, 1'b0);
    chk("rd_vld_early", o_rd_valid, 1'b0);
    tick();
    chk("rd_vld", o_rd_valid, 1'b1);
    chk("rd_data", o_rd_data, 16'h83C1);
    chk("rd_oe_hi", o_sram_oe_n, 1'b1);
    i_rd_req = 1'b0;
    tick();
    chk("rd_vld_pulse", o_rd_valid, 1'b0);
    chk("rd_hold", o_rd_data, 16'h83C1);

    // Three queued writes against a pending read alternate W, R, W, W.
    grant_log.delete();
    push(20'h00050, 16'hB000);
    i_rd_addr = 20'h00003;
    i_rd_req  = 1'b1;
    push(20'h00051, 16'hB001);
    push(20'h00052, 16'hB002);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (o_rd_valid) seen = 1'b1;
      else tick();
    end
    chk("arb_rd_seen", seen, 1'b1);
    chk("arb_rd_data", o_rd_data, 16'hF2CF);
    i_rd_req = 1'b0;
    repeat (12) tick();
    chk("arb_n", grant_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < grant_log.size()) chk("arb_order", grant_log[i], exp_ord[i]);
    chk("arb_end", o_end_addr, 20'h00052);
    chk("arb_mem", sram_mem[8'h51], 16'hB001);

    // Clear during the write of 0x20 with two more samples queued.
    push(20'h00020, 16'hAAAA);
    push(20'h00021, 16'hBBBB);
    push(20'h00022, 16'hCCCC);
    chk("cw_writing", o_sram_we_n, 1'b0);
    i_rec_clear = 1'b1;
    tick();
    i_rec_clear = 1'b0;
    chk("cw_done_we", o_sram_we_n, 1'b1);
    repeat (6) tick();
    chk("cw_mem20", sram_mem[8'h20], 16'hAAAA);
    chk("cw_mem21", sram_mem[8'h21], preload(8'h21));
    chk("cw_end", o_end_addr, 20'h0);
    chk("cw_has", o_has_data, 1'b0);

    // Clear and a new sample in the same cycle: the sample survives.
    i_rec_clear = 1'b1;
    push(20'h00030, 16'h3030);
    i_rec_clear = 1'b0;
    repeat (5) tick();
    chk("cv_end", o_end_addr, 20'h00030);
    chk("cv_has", o_has_data, 1'b1);
    chk("cv_mem", sram_mem[8'h30], 16'h3030);

    // Asynchronous reset in the middle of a read.
    i_rd_addr = 20'h00003;
    i_rd_req  = 1'b1;
    tick();
    chk("ar_oe_lo", o_sram_oe_n, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("ar_oe", o_sram_oe_n, 1'b1);
    chk("ar_we", o_sram_we_n, 1'b1);
    chk("ar_addr", o_sram_addr, 20'h0);
    chk("ar_flags", {o_rd_valid, o_has_data, o_overflow}, 3'b000);
    chk("ar_data", {o_rd_data, o_end_addr}, 36'h0);
    i_rd_req = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_rd_valid) pulses++;
    end
    chk("ar_no_valid", pulses, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aud_sram_ctrl.md
# aud_sram_ctrl

Single-port SRAM controller sitting directly downstream of the audio recorder in the lab3 record/playback path. It absorbs the recorder's (20-bit address, 16-bit sample) stream in a small FIFO, commits each sample to the external 1M×16 SRAM, and arbitrates the same SRAM for a playback-side read port. It also tracks the last address written so playback knows where the recording ends.

## Interface
- FIFO_DEPTH, 4: recorder-side write FIFO entries, power of two, ≥2
- WR_CYCLES, 2: cycles WE_N is held low per write, ≥1
- RD_CYCLES, 2: cycles OE_N is held low per read, ≥1

Ports (one clock; reset is asynchronous and active-low):
- i_clk  in  1  system clock, same as recorder BCLK domain
- i_rst_n  in  1  asynchronous active-low reset
- i_rec_valid  in  1  one-cycle strobe: i_rec_addr/i_rec_data hold a new sample
- i_rec_addr  in  20  SRAM word address of sample
- i_rec_data  in  16  sample value
- i_rec_clear  in  1  one-cycle pulse at start of a new recording
- o_overflow  out  1  sticky: a sample was dropped because the FIFO was full
- i_rd_req  in  1  read request; held high until o_rd_valid
- i_rd_addr  in  20  read address, stable while i_rd_req high
- o_rd_valid  out  1  one-cycle pulse: o_rd_data valid
- o_rd_data  out  16  read data, held until next read completes
- o_end_addr  out  20  address of last completed write
- o_has_data  out  1  at least one write completed since reset/clear
- o_sram_addr  out  20  SRAM address
- io_sram_dq  inout  16  SRAM data, driven only in WRITE
- o_sram_we_n, o_sram_oe_n  out  1 each  write/output enable, active low
- o_sram_ce_n, o_sram_lb_n, o_sram_ub_n  out  1 each  constant 0

## Operation
- FIFO: push on i_rec_valid; full-and-no-pop → sample dropped, o_overflow set. Push and pop same edge while full → push accepted, no overflow.
- FSM states IDLE, WRITE, READ; all SRAM controls registered.
- IDLE → WRITE: FIFO non-empty and (no read pending or last grant was READ). Latches head entry onto o_sram_addr/dq, we_n=0.
- IDLE → READ: i_rd_req, o_rd_valid low, and (FIFO empty or last grant was WRITE). Latches i_rd_addr, oe_n=0.
- Fairness: with both pending, grants alternate WRITE/READ; after reset "last grant" = READ (write wins first).
- WRITE: stays WR_CYCLES cycles, then → IDLE, we_n=1, dq released, FIFO pops, o_end_addr ← written address, o_has_data=1.
- READ: stays RD_CYCLES cycles; on the final edge captures io_sram_dq into o_rd_data, oe_n=1, → IDLE, o_rd_valid=1 for the next cycle.
- i_rec_clear: flushes FIFO, clears o_overflow, o_end_addr=0, o_has_data=0. An in-progress write completes on the SRAM but does not update o_end_addr/o_has_data. Clear and i_rec_valid same cycle → sample pushed into the emptied FIFO.
- Reset mid-operation: all state cleared immediately; SRAM access aborted.

## Timing
- Reset values: o_sram_we_n=1, o_sram_oe_n=1, ce/lb/ub_n=0, o_sram_addr=0, dq high-Z, o_rd_valid=0, o_rd_data=0, o_end_addr=0, o_has_data=0, o_overflow=0, FSM IDLE, FIFO empty.
- Write latency: push at edge N; we_n low cycles N+1..N+WR_CYCLES; pop and o_end_addr update at edge N+1+WR_CYCLES.
- Read latency: request seen in IDLE at edge M; oe_n low for RD_CYCLES cycles; o_rd_valid high in cycle M+RD_CYCLES+1.
- Sustained write throughput: one sample per WR_CYCLES+1 cycles; never exceeds FIFO at recorder rate (≤1 sample per 16 clocks).
- Address/data stable for the full WE_N/OE_N low window; dq driven only while we_n=0.

## Test plan
- Single write: valid addr=0x00003 data=0xF2CF after reset → we_n low 2 cycles, dq=0xF2CF, o_end_addr=0x00003, o_has_data=1 at edge N+3.
- Overflow: 6 valids on consecutive cycles (FIFO_DEPTH=4) → ≥1 dropped, o_overflow=1; i_rec_clear → o_overflow=0, o_end_addr=0, o_has_data=0.
- Read: SRAM model holds 0x83C1 at 0x00010, i_rd_req addr 0x00010 while FIFO empty → oe_n low 2 cycles, o_rd_valid pulse with o_rd_data=0x83C1 at M+3.
- Arbitration: 3 queued writes and a pending read → order WRITE, READ, WRITE, WRITE; read data correct; no overlap of we_n/oe_n low.
- Clear mid-write: clear during WRITE of addr 0x00020 with 2 queued → write completes, queue empty, o_end_addr=0, o_has_data=0.
- Async reset during READ → all outputs at reset values immediately, no o_rd_valid pulse.
